// File: rtl/clk_div_monitor_if.sv
// Bundles the monitor's control input, the divided clock it measures, and
// the published measurement.
//   master: enable, div_clk -> monitor; consumes period, high_time,
//           meas_valid, meas_count, overflow
//   slave : the monitor side of the same signals
interface clk_div_monitor_if #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned MCNT_W = 8
) ();
    logic              enable;
    logic              div_clk;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  high_time;
    logic              meas_valid;
    logic [MCNT_W-1:0] meas_count;
    logic              overflow;

    modport master (
        output enable, div_clk,
        input  period, high_time, meas_valid, meas_count, overflow
    );

    modport slave (
        input  enable, div_clk,
        output period, high_time, meas_valid, meas_count, overflow
    );
endinterface

// File: rtl/clk_div_monitor.sv
// Measures the period (rise to rise) and high time (rise to fall) of a
// divided clock in clk_in cycles and publishes each completed measurement.
//   clk_in  : system clock, same clock that drives the divider
//   rst     : synchronous, active-high reset
//   bus     : enable/div_clk in; period, high_time, meas_valid (1-cycle
//             strobe), meas_count (wrapping), overflow (sticky) out
module clk_div_monitor #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned MCNT_W = 8
) (
    input  logic               clk_in,
    input  logic               rst,
    clk_div_monitor_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        OVF     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              s0_q, s1_q;
    logic              seen_low_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  h_lat_q, h_lat_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic              valid_q, valid_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic              ovf_q, ovf_d;

    logic rise_c;
    logic fall_c;
    logic sat_c;

    // A level that is already high when reset releases must be seen low
    // before its next rising transition can count as a rise.
    assign rise_c = s0_q & ~s1_q & seen_low_q;
    assign fall_c = ~s0_q & s1_q;
    assign sat_c  = (cnt_q == CNT_MAX);

    // Two-flop sampler of the divided clock plus the low-seen qualifier.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            s0_q       <= bus.div_clk;
            s1_q       <= s0_q;
            seen_low_q <= seen_low_q | ~bus.div_clk;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            h_lat_q  <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            mcnt_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            h_lat_q  <= h_lat_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            mcnt_q   <= mcnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state and next-output logic; enable low overrides every state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        h_lat_d  = h_lat_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        mcnt_d   = mcnt_q;
        ovf_d    = ovf_q;

        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                end
                ARM: begin
                    // First rise only establishes the reference edge.
                    if (rise_c) begin
                        cnt_d   = CNT_W'(1);
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise_c) begin
                        // A rise beats saturation in the same cycle.
                        period_d = cnt_q;
                        high_d   = h_lat_q;
                        valid_d  = 1'b1;
                        mcnt_d   = mcnt_q + MCNT_W'(1);
                        cnt_d    = CNT_W'(1);
                    end else begin
                        if (fall_c) begin
                            h_lat_d = cnt_q;
                        end
                        if (sat_c) begin
                            ovf_d   = 1'b1;
                            state_d = OVF;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                OVF: begin
                    // The period in progress is unusable; restart from this rise.
                    if (rise_c) begin
                        cnt_d   = CNT_W'(1);
                        state_d = MEASURE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.period     = period_q;
    assign bus.high_time  = high_q;
    assign bus.meas_valid = valid_q;
    assign bus.meas_count = mcnt_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Drives two monitors (default widths and a narrow 6-bit/2-bit build) with
// the same divided-clock waveform and compares every output, every cycle,
// against a timestamp-based reference model.
module tb_clk_div_monitor;

    logic clk_in = 1'b0;
    logic rst;
    logic en;
    logic dclk;

    always #5 clk_in = ~clk_in;

    clk_div_monitor_if #(.CNT_W(16), .MCNT_W(8)) bus_a ();
    clk_div_monitor_if #(.CNT_W(6),  .MCNT_W(2)) bus_b ();

    assign bus_a.enable  = en;
    assign bus_a.div_clk = dclk;
    assign bus_b.enable  = en;
    assign bus_b.div_clk = dclk;

    clk_div_monitor #(.CNT_W(16), .MCNT_W(8)) dut_a (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus_a)
    );

    clk_div_monitor #(.CNT_W(6), .MCNT_W(2)) dut_b (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus_b)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: measurements are differences of the cycle indices at
    // which the driven waveform rose and fell.
    int max_cnt [2] = '{65535, 63};
    int mmod    [2] = '{256, 4};
    int m_period[2];
    int m_high  [2];
    int m_count [2];
    int m_valid [2];
    int m_ovf   [2];
    int m_ref   [2];
    int m_inovf [2];
    int m_idle  [2];

    int   cyc       = 0;
    int   last_fall = 0;
    logic h1 = 1'b0, h2 = 1'b0;
    logic rh1 = 1'b1, rh2 = 1'b1;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    endtask

    task automatic model_step(input logic e, input logic r);
        logic rise_ev;
        logic fall_ev;
        // The waveform rose at cycle cyc-1 if it was low one cycle earlier
        // and neither sample was taken under reset.
        rise_ev = h1 & ~h2 & ~rh1 & ~rh2;
        fall_ev = ~h1 & h2;
        if (fall_ev) last_fall = cyc - 1;
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0;
            if (r) begin
                m_period[k] = 0; m_high[k] = 0; m_count[k] = 0; m_ovf[k] = 0;
                m_ref[k] = -1; m_inovf[k] = 0; m_idle[k] = 1;
            end else if (!e) begin
                m_ovf[k] = 0; m_ref[k] = -1; m_inovf[k] = 0; m_idle[k] = 1;
            end else if (m_idle[k] != 0) begin
                m_idle[k] = 0;
            end else if (rise_ev) begin
                if (m_ref[k] >= 0 && m_inovf[k] == 0) begin
                    m_period[k] = (cyc - 1) - m_ref[k];
                    m_high[k]   = last_fall - m_ref[k];
                    m_valid[k]  = 1;
                    m_count[k]  = (m_count[k] + 1) % mmod[k];
                end
                m_ref[k]   = cyc - 1;
                m_inovf[k] = 0;
            end else if (m_ref[k] >= 0 && m_inovf[k] == 0 &&
                         (cyc - 1 - m_ref[k]) == max_cnt[k]) begin
                m_ovf[k]   = 1;
                m_inovf[k] = 1;
            end
        end
    endtask

    // One clk_in cycle: drive at the falling edge, model at the rising edge,
    // compare at the next falling edge.
    task automatic cycle(input logic d, input logic e, input logic r);
        dclk = d;
        en   = e;
        rst  = r;
        @(posedge clk_in);
        cyc++;
        model_step(e, r);
        @(negedge clk_in);
        check("a.period",     int'(bus_a.period),     m_period[0]);
        check("a.high_time",  int'(bus_a.high_time),  m_high[0]);
        check("a.meas_valid", int'(bus_a.meas_valid), m_valid[0]);
        check("a.meas_count", int'(bus_a.meas_count), m_count[0]);
        check("a.overflow",   int'(bus_a.overflow),   m_ovf[0]);
        check("b.period",     int'(bus_b.period),     m_period[1]);
        check("b.high_time",  int'(bus_b.high_time),  m_high[1]);
        check("b.meas_valid", int'(bus_b.meas_valid), m_valid[1]);
        check("b.meas_count", int'(bus_b.meas_count), m_count[1]);
        check("b.overflow",   int'(bus_b.overflow),   m_ovf[1]);
        h2  = h1;
        h1  = d;
        rh2 = rh1;
        rh1 = r;
    endtask

    // n periods of hi cycles high then lo cycles low; optional enable-low
    // window and one-cycle reset, at offsets counted from the task start.
    task automatic run_ev(input int hi, input int lo, input int n,
                          input int dis_at, input int dis_len, input int rst_at);
        int   off;
        logic d;
        logic e;
        logic r;
        off = 0;
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < hi + lo; c++) begin
                d = (c < hi);
                e = !(dis_at >= 0 && off >= dis_at && off < dis_at + dis_len);
                r = (off == rst_at);
                cycle(d, e, r);
                off++;
            end
        end
    endtask

    task automatic run(input int hi, input int lo, input int n);
        run_ev(hi, lo, n, -1, 0, -1);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_period[k] = 0; m_high[k] = 0; m_count[k] = 0; m_valid[k] = 0;
            m_ovf[k] = 0; m_ref[k] = -1; m_inovf[k] = 0; m_idle[k] = 1;
        end

        // Reset with enable already high.
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);

        // Symmetric divide-by-8.
        run(4, 4, 5);

        // Asymmetric, then a mid-run change of shape.
        run(3, 10, 3);
        run(5, 5, 3);

        // Random legal shapes.
        repeat (6) run(int'($urandom_range(12, 1)), int'($urandom_range(12, 1)), 2);

        // Long low phase: narrow build saturates, wide build measures 104.
        run(4, 100, 1);
        run(4, 4, 3);

        // Period exactly at the narrow saturation limit, then one past it.
        run(30, 33, 3);
        run(30, 34, 2);
        run(4, 4, 2);

        // Enable dropped mid-measurement, and dropped on a rise's detect cycle.
        run_ev(4, 4, 4, 10, 2, -1);
        run_ev(4, 4, 4, 17, 1, -1);

        // Reset while the divided clock is high, then while it is low.
        run_ev(4, 4, 4, -1, 0, 10);
        run_ev(4, 4, 4, -1, 0, 13);

        // Divide-by-6 long enough to wrap the narrow measurement counter.
        run(3, 3, 6);

        // Random shapes with random enable-low windows.
        repeat (8) run_ev(int'($urandom_range(9, 1)), int'($urandom_range(9, 1)), 3,
                          int'($urandom_range(30, 0)), int'($urandom_range(3, 1)), -1);

        run(2, 3, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Downstream consumer of the clock divider output (clk_out).
- Samples the divided clock in the clk_in domain and measures its period and high time in clk_in cycles.
- Publishes each completed measurement with a one-cycle valid strobe, a wrapping measurement counter and a sticky overflow flag.
- Used on-chip to self-check the divider against the programmed scale and to drive a debug readout.

Parameters:
- CNT_W, 16, width of the period/high-time counters and outputs.
- MCNT_W, 8, width of the completed-measurement counter.

Ports:
- clk_in  input  1  system clock; same clock that drives the divider.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  1 = measure; 0 = return to IDLE.
- div_clk  input  1  divided clock from the clock divider.
- period  output  CNT_W  last measured period, rise to rise, in clk_in cycles.
- high_time  output  CNT_W  last measured high time, rise to fall, in clk_in cycles.
- meas_valid  output  1  one-cycle pulse when period/high_time update.
- meas_count  output  MCNT_W  number of completed measurements, wraps.
- overflow  output  1  sticky; counter saturated before the next rise.

Behaviour:
- Sampling: s0 <= div_clk; s1 <= s0; rise = s0 & ~s1; fall = ~s0 & s1. Both flops are cleared by rst.
- Reset: all outputs are 0, the FSM is in IDLE, and cnt, h_lat, s0 and s1 are 0.
- FSM states: IDLE, ARM, MEASURE, OVF.
  - IDLE: move to ARM when enable = 1.
  - ARM: wait for rise. On rise, cnt <= 1 and go to MEASURE. A fall in ARM is ignored. No valid is produced for this first rise.
  - MEASURE: each cycle cnt <= cnt + 1.
    - On fall: h_lat <= cnt.
    - On rise: period <= cnt; high_time <= h_lat; meas_valid <= 1; meas_count <= meas_count + 1; cnt <= 1.
    - If cnt = 2^CNT_W - 1 with no rise: overflow <= 1 and go to OVF.
  - OVF: cnt holds. On rise, cnt <= 1 and go to MEASURE. No valid is produced for this rise.
- enable = 0 in any state: go to IDLE next cycle. cnt is cleared, overflow is cleared, meas_valid = 0. period, high_time and meas_count hold.
- Counting convention: if rise is detected at cycle t, then cnt = k at cycle t + k. A div_clk with period P cycles and high time H cycles therefore reports period = P and high_time = H exactly.
- Latency: meas_valid is high for exactly one cycle.
  - It starts in the cycle after the second clk_in edge following the div_clk rising transition.
  - That is: edge 1 loads s0, the detect cycle follows, and edge 2 registers the outputs.
- period and high_time are stable between meas_valid pulses.
- Simultaneous events:
  - rise and the saturation condition in the same cycle: the rise wins. A normal measurement is taken and overflow is not set.
  - rise and enable falling in the same cycle: enable wins. No valid is produced.
- Overflow is sticky through later valid measurements and clears only on rst or enable = 0.
- rst mid-measurement: cleared next edge. Re-arming requires a fresh rise; a div_clk high at reset release is not a rise until it has been seen low.
- meas_count wraps from 2^MCNT_W - 1 to 0.
- Arithmetic:
  - cnt saturates and never wraps.
  - high_time < period always holds for legal inputs.
  - h_lat is not reset between measurements; it is always rewritten by the fall preceding the next rise.

Test Plan:
- Divider toggling every 4 clk_in cycles (P = 8, H = 4), enable = 1 from reset: first rise gives no valid. The second rise gives period = 8, high_time = 4, meas_valid for 1 cycle, meas_count = 1. Each later period gives the same values, with meas_count incrementing.
- Asymmetric div_clk, high 3 and low 10 cycles: period = 13, high_time = 3. Changing to high 5 / low 5 mid-run: the first full new period reports 10/5 with no stale mix.
- CNT_W = 6, div_clk held low for 100 cycles after arming: overflow = 1 at cnt = 63 and the FSM enters OVF. The next rise gives no valid. The following rise gives a normal valid measurement, and overflow is still 1.
- Deassert enable mid-MEASURE for 2 cycles, then reassert: overflow = 0. The first rise after reassertion gives no valid and the second does. period and meas_count hold their pre-disable values until then.
- Assert rst for 1 cycle between two rises (P = 8): all outputs are 0. The next rise only arms, and the measurement after that reports 8.
- MCNT_W = 2, run 5 periods at P = 6: meas_count sequence is 1, 2, 3, 0, with meas_valid pulses exactly 6 cycles apart.
